// File: rtl/counter_demux.sv
// counter_demux: cycle counter with periodic or sticky flag, plus binary-to-one-hot wait-source decoder
module counter_demux #(
  parameter int COUNT = 2,
  parameter int RESET = 1,
  parameter int BITS = 2,
  localparam int W = COUNT > 1 ? $clog2(COUNT) : 1,
  localparam int N = 2**BITS + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          flag,
  output logic [W-1:0]  count,
  input  logic [BITS-1:0] val,
  output logic [N-1:0]  sel
);
  localparam logic [W-1:0] LAST = W'(COUNT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (count == LAST) begin
      count <= RESET != 0 ? '0 : count;
      flag  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      flag  <= 1'b0;
    end
  end
  assign sel = {{(N-1){1'b0}}, 1'b1} << val;
endmodule

// File: tb/tb_counter_demux.sv
// tb_counter_demux: checks six counter configurations and the decoder against an arithmetic model
module tb_counter_demux;
  logic clk;
  logic [5:0] rst;
  logic [5:0] f;
  logic [1:0] val;
  logic [4:0] sel;
  logic [4:0] sel1, sel2, sel3, sel4, sel5;
  logic [0:0] c0, c4, c5;
  logic [4:0] c1, c3;
  logic [11:0] c2;
  int k[6];
  int tests = 0;
  int fails = 0;
  int hi2 = 0;
  int hi2_edges[$];
  localparam int CNT[6] = '{2, 20, 2500, 20, 1, 1};
  localparam int RLD[6] = '{1, 0, 1, 1, 1, 0};

  counter_demux #(.COUNT(2),    .RESET(1), .BITS(2)) u0 (.clk(clk), .rst(rst[0]), .flag(f[0]), .count(c0), .val(val), .sel(sel));
  counter_demux #(.COUNT(20),   .RESET(0), .BITS(2)) u1 (.clk(clk), .rst(rst[1]), .flag(f[1]), .count(c1), .val(val), .sel(sel1));
  counter_demux #(.COUNT(2500), .RESET(1), .BITS(2)) u2 (.clk(clk), .rst(rst[2]), .flag(f[2]), .count(c2), .val(val), .sel(sel2));
  counter_demux #(.COUNT(20),   .RESET(1), .BITS(2)) u3 (.clk(clk), .rst(rst[3]), .flag(f[3]), .count(c3), .val(val), .sel(sel3));
  counter_demux #(.COUNT(1),    .RESET(1), .BITS(2)) u4 (.clk(clk), .rst(rst[4]), .flag(f[4]), .count(c4), .val(val), .sel(sel4));
  counter_demux #(.COUNT(1),    .RESET(0), .BITS(2)) u5 (.clk(clk), .rst(rst[5]), .flag(f[5]), .count(c5), .val(val), .sel(sel5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k[i] = number of edges since the edge that last sampled reset
  always @(posedge clk)
    for (int i = 0; i < 6; i++) k[i] <= rst[i] ? 0 : k[i] + 1;

  function automatic int ecount(int c, int r, int e);
    return r != 0 ? e % c : (e < c - 1 ? e : c - 1);
  endfunction

  function automatic int eflag(int c, int r, int e);
    return r != 0 ? int'(e > 0 && e % c == 0) : int'(e >= c);
  endfunction

  task automatic chk(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic step();
    int cv[6];
    int es;
    @(negedge clk);
    cv = '{int'(c0), int'(c1), int'(c2), int'(c3), int'(c4), int'(c5)};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("u%0d_count", i), cv[i], ecount(CNT[i], RLD[i], k[i]));
      chk($sformatf("u%0d_flag", i), int'(f[i]), eflag(CNT[i], RLD[i], k[i]));
    end
    es = 0;
    for (int j = 0; j < 4; j++) if (int'(val) == j) es += 2**j;
    chk("sel_follow", int'(sel), es);
    if (f[2]) begin
      hi2++;
      hi2_edges.push_back(k[2]);
    end
  endtask

  typedef struct {
    logic [1:0] v;
    logic       r;
    logic [4:0] s;
  } dec_vec_t;

  initial begin
    dec_vec_t dv[8];
    int t1_flag[8];
    int t1_count[8];
    dv[0] = '{2'd0, 1'b0, 5'b00001};
    dv[1] = '{2'd1, 1'b0, 5'b00010};
    dv[2] = '{2'd2, 1'b0, 5'b00100};
    dv[3] = '{2'd3, 1'b0, 5'b01000};
    dv[4] = '{2'd3, 1'b1, 5'b01000};
    dv[5] = '{2'd2, 1'b1, 5'b00100};
    dv[6] = '{2'd1, 1'b1, 5'b00010};
    dv[7] = '{2'd0, 1'b1, 5'b00001};
    t1_flag  = '{0, 1, 0, 1, 0, 1, 0, 1};
    t1_count = '{1, 0, 1, 0, 1, 0, 1, 0};
    rst = '1;
    val = 2'd0;
    step();
    chk("reset_count0", int'(c0), 0);
    chk("reset_flag_any", int'(f), 0);
    rst = '0;
    for (int i = 0; i < 8; i++) begin
      val = dv[i].v;
      rst[0] = dv[i].r;
      #1;
      chk($sformatf("dec_tbl%0d", i), int'(sel), int'(dv[i].s));
      chk($sformatf("dec_spare%0d", i), int'(sel[4]), 0);
      step();
    end
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t1_flag_e%0d", i + 1), int'(f[0]), t1_flag[i]);
      chk($sformatf("t1_count_e%0d", i + 1), int'(c0), t1_count[i]);
    end
    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
    repeat (9) step();
    rst[3] = 1'b1;
    step();
    chk("t4_mid_count", int'(c3), 0);
    chk("t4_mid_flag", int'(f[3]), 0);
    rst[3] = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      chk($sformatf("t4_after_e%0d", e), int'(f[3]), int'(e == 20));
    end
    repeat (19) step();
    chk("t4_pre_terminal", int'(c3), 19);
    rst[3] = 1'b1;
    step();
    chk("t4_term_flag", int'(f[3]), 0);
    chk("t4_term_count", int'(c3), 0);
    rst[3] = 1'b0;
    repeat (19) begin
      step();
      chk("t4_term_quiet", int'(f[3]), 0);
    end
    rst[5:4] = 2'b11;
    step();
    chk("t5_reset_r1", int'(f[4]), 0);
    chk("t5_reset_r0", int'(f[5]), 0);
    rst[5:4] = 2'b00;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("t5_r1_e%0d", e), int'(f[4]), 1);
      chk($sformatf("t5_r0_e%0d", e), int'(f[5]), 1);
    end
    for (int n = 0; n < 600; n++) begin
      val = 2'($urandom_range(3));
      rst[0] = ($urandom_range(15) == 0);
      rst[3] = ($urandom_range(31) == 0);
      rst[4] = ($urandom_range(7) == 0);
      rst[5] = ($urandom_range(7) == 0);
      step();
    end
    rst = '0;
    while (k[2] < 5001) step();
    chk("t2_hold_count", int'(c1), 19);
    chk("t2_sticky_flag", int'(f[1]), 1);
    chk("t3_pulse_total", hi2, 2);
    chk("t3_first_edge", hi2_edges.size() > 0 ? hi2_edges[0] : -1, 2500);
    chk("t3_second_edge", hi2_edges.size() > 1 ? hi2_edges[1] : -1, 5000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
